morse_key_encoder: RTL



---
 rtl/morse_key_encoder_if.sv | 24 ++
 rtl/morse_key_encoder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/morse_key_encoder_if.sv
// Key-side interface of the Morse key encoder: raw key in, committed code and status out.
interface morse_key_encoder_if;
   logic        KEY;
   logic [15:0] MOSE;
   logic        MOSE_VLD;
   logic        BUSY;
   logic        OVF;

   modport master (
      output KEY,
      input  MOSE,
      input  MOSE_VLD,
      input  BUSY,
      input  OVF
   );

   modport slave (
      input  KEY,
      output MOSE,
      output MOSE_VLD,
      output BUSY,
      output OVF
   );
endinterface

// File: rtl/morse_key_encoder.sv
// Debounces a push-button key, classifies dot/dash and packs one MOSE code per letter.
// Optional word-space emission after long idle is enabled with `define MORSE_WORD_GAP_EN.
module morse_key_encoder #(
   parameter int unsigned DEBOUNCE_CYC = 500000,
   parameter int unsigned DASH_CYC     = 30000000,
   parameter int unsigned GAP_CYC      = 80000000,
   parameter int unsigned WORD_CYC     = 160000000,
   parameter int unsigned CNT_W        = 28
) (
   input logic               CLK,
   input logic               RST,
   morse_key_encoder_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StPress, StGap} state_t;

   logic [1:0]       sync_q;
   logic             db_q;
   logic [CNT_W-1:0] db_cnt_q;
   logic             db_differ;
   logic             db_flip;
   logic             key_rise;
   logic             key_fall;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [CNT_W-1:0] timer_inc;
   logic [15:0]      acc_q, acc_d;
   logic             ovf_flag_q, ovf_flag_d;
   logic [15:0]      mose_q, mose_d;
   logic             vld_q, vld_d;
   logic             ovf_q, ovf_d;
   logic             is_dash;
`ifdef MORSE_WORD_GAP_EN
   logic             armed_q, armed_d;
`endif

   assign db_differ = (sync_q[1] != db_q);
   assign db_flip   = db_differ && (db_cnt_q == CNT_W'(DEBOUNCE_CYC - 1));
   // Edge events fire in the cycle the debounced key is about to change.
   assign key_rise  = db_flip && sync_q[1];
   assign key_fall  = db_flip && !sync_q[1];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync_q   <= 2'b00;
         db_q     <= 1'b0;
         db_cnt_q <= '0;
      end else begin
         sync_q <= {sync_q[0], bus.KEY};
         if (db_flip) begin
            db_q     <= sync_q[1];
            db_cnt_q <= '0;
         end else if (db_differ) begin
            db_cnt_q <= db_cnt_q + CNT_W'(1);
         end else begin
            db_cnt_q <= '0;
         end
      end
   end

   assign timer_inc = (timer_q == '1) ? timer_q : timer_q + CNT_W'(1);
   // Press length counts the cycle of the fall itself, so compare the incremented value.
   assign is_dash   = (timer_inc >= CNT_W'(DASH_CYC));

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      acc_d      = acc_q;
      ovf_flag_d = ovf_flag_q;
      mose_d     = mose_q;
      vld_d      = 1'b0;
      ovf_d      = ovf_q;
`ifdef MORSE_WORD_GAP_EN
      armed_d    = armed_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (key_rise) begin
               state_d = StPress;
               timer_d = '0;
            end
`ifdef MORSE_WORD_GAP_EN
            else if (armed_q) begin
               if (timer_q == CNT_W'(WORD_CYC - 1)) begin
                  mose_d  = 16'h0020;
                  ovf_d   = 1'b0;
                  vld_d   = 1'b1;
                  armed_d = 1'b0;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + CNT_W'(1);
               end
            end
`endif
         end
         StPress: begin
            timer_d = timer_inc;
            if (key_fall) begin
               if (acc_q == 16'h0000) begin
                  acc_d = is_dash ? 16'h0003 : 16'h0001;
               end else if (is_dash) begin
                  if (acc_q[15:13] != 3'b000) ovf_flag_d = 1'b1;
                  else                        acc_d = {acc_q[12:0], 3'b011};
               end else begin
                  if (acc_q[15:14] != 2'b00) ovf_flag_d = 1'b1;
                  else                       acc_d = {acc_q[13:0], 2'b01};
               end
               state_d = StGap;
               timer_d = '0;
            end
         end
         StGap: begin
            if (key_rise) begin
               state_d = StPress;
               timer_d = '0;
            end else if (timer_q == CNT_W'(GAP_CYC - 1)) begin
               mose_d     = ovf_flag_q ? 16'h0000 : acc_q;
               ovf_d      = ovf_flag_q;
               vld_d      = 1'b1;
               acc_d      = 16'h0000;
               ovf_flag_d = 1'b0;
`ifdef MORSE_WORD_GAP_EN
               armed_d    = 1'b1;
`endif
               state_d    = StIdle;
               timer_d    = '0;
            end else begin
               timer_d = timer_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = StIdle;
            timer_d = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= StIdle;
         timer_q    <= '0;
         acc_q      <= 16'h0000;
         ovf_flag_q <= 1'b0;
         mose_q     <= 16'h0000;
         vld_q      <= 1'b0;
         ovf_q      <= 1'b0;
`ifdef MORSE_WORD_GAP_EN
         armed_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         acc_q      <= acc_d;
         ovf_flag_q <= ovf_flag_d;
         mose_q     <= mose_d;
         vld_q      <= vld_d;
         ovf_q      <= ovf_d;
`ifdef MORSE_WORD_GAP_EN
         armed_q    <= armed_d;
`endif
      end
   end

   assign bus.MOSE     = mose_q;
   assign bus.MOSE_VLD = vld_q;
   assign bus.BUSY     = (state_q != StIdle);
   assign bus.OVF      = ovf_q;

endmodule
